// File: rtl/jpeg_block_sequencer.sv
// Block sequencer for the 8x8 zigzag/DC-difference buffer: fires the fill, waits out
// fill + zigzag latency, presents the block downstream, and tracks MCU order and restart markers.
module jpeg_block_sequencer #(
  parameter int unsigned FILL_CYCLES = 11,
  parameter int unsigned ZZ_LATENCY  = 2,
  parameter int unsigned Y_BLOCKS    = 4,
  parameter int unsigned MCU_CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic [MCU_CNT_W-1:0] restart_interval,
  input  logic                 blk_start_valid,
  output logic                 blk_start_ready,
  output logic                 input_enable,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 input_data_enable,
  output logic                 dc_pred_clear,
  output logic [1:0]           comp_id,
  output logic                 last_block_in_mcu,
  output logic [MCU_CNT_W-1:0] mcu_count,
  output logic                 restart_marker_req,
  input  logic                 restart_marker_ack,
  output logic                 busy
);

  localparam int unsigned WAIT_LAST = FILL_CYCLES + ZZ_LATENCY - 1;
  localparam int unsigned CNT_W     = $clog2(WAIT_LAST + 1) + 1;
  localparam int unsigned IDX_W     = $clog2(Y_BLOCKS + 2);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PRESENT, S_RSTMK} state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     blk_idx, blk_idx_d;
  logic [MCU_CNT_W-1:0] rst_cnt, rst_cnt_d;
  logic [MCU_CNT_W-1:0] mcu_cnt, mcu_cnt_d;
  logic [MCU_CNT_W-1:0] rst_cnt_inc;
  logic                 ie_d, ide_d, dcc_d, last_d;
  logic [1:0]           comp_d;
  logic                 ready_q, ie_q, ov_q, ide_q, dcc_q, last_q, req_q, busy_q;
  logic [1:0]           comp_q;

  assign rst_cnt_inc = rst_cnt + MCU_CNT_W'(1);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    blk_idx_d = blk_idx;
    rst_cnt_d = rst_cnt;
    mcu_cnt_d = mcu_cnt;
    ie_d      = 1'b0;
    ide_d     = 1'b0;
    dcc_d     = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          blk_idx_d = '0;
          rst_cnt_d = '0;
          mcu_cnt_d = '0;
          dcc_d     = 1'b1;
        end else if (blk_start_valid && ready_q) begin
          state_d = S_FILL;
          cnt_d   = '0;
          ie_d    = 1'b1;
        end
      end
      S_FILL: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WAIT_LAST)) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready) begin
          ide_d   = 1'b1;
          state_d = S_IDLE;
          if (blk_idx == IDX_W'(Y_BLOCKS + 1)) begin
            blk_idx_d = '0;
            mcu_cnt_d = mcu_cnt + MCU_CNT_W'(1);
            rst_cnt_d = rst_cnt_inc;
            if ((restart_interval != '0) && (rst_cnt_inc == restart_interval))
              state_d = S_RSTMK;
          end else begin
            blk_idx_d = blk_idx + IDX_W'(1);
          end
        end
      end
      S_RSTMK: begin
        if (restart_marker_ack) begin
          rst_cnt_d = '0;
          dcc_d     = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Component tag follows the next block index so it is settled before FILL entry.
  always_comb begin
    comp_d = 2'd2;
    if (blk_idx_d < IDX_W'(Y_BLOCKS))       comp_d = 2'd0;
    else if (blk_idx_d == IDX_W'(Y_BLOCKS)) comp_d = 2'd1;
    last_d = (blk_idx_d == IDX_W'(Y_BLOCKS + 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      blk_idx <= '0;
      rst_cnt <= '0;
      mcu_cnt <= '0;
      ready_q <= 1'b1;
      ie_q    <= 1'b0;
      ov_q    <= 1'b0;
      ide_q   <= 1'b0;
      dcc_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      comp_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      blk_idx <= blk_idx_d;
      rst_cnt <= rst_cnt_d;
      mcu_cnt <= mcu_cnt_d;
      ready_q <= (state_d == S_IDLE);
      ie_q    <= ie_d;
      ov_q    <= (state_d == S_PRESENT);
      ide_q   <= ide_d;
      dcc_q   <= dcc_d;
      req_q   <= (state_d == S_RSTMK);
      busy_q  <= (state_d != S_IDLE);
      comp_q  <= comp_d;
      last_q  <= last_d;
    end
  end

  // frame_start takes priority over a handshake, so ready is withheld in that cycle.
  assign blk_start_ready    = ready_q & ~frame_start;
  assign input_enable       = ie_q;
  assign out_valid          = ov_q;
  assign input_data_enable  = ide_q;
  assign dc_pred_clear      = dcc_q;
  assign comp_id            = comp_q;
  assign last_block_in_mcu  = last_q;
  assign mcu_count          = mcu_cnt;
  assign restart_marker_req = req_q;
  assign busy               = busy_q;

endmodule
